id_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the ID-stage load-use detector. A shift-register

---
 rtl/id_hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard.
// A shift register tracks the destinations of instructions that have left ID,
// one entry per pipeline stage for LOAD_LAT+1 stages. An ID instruction is held
// until every source it reads can be forwarded from its youngest producer.
module id_hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
  input  logic [NUM_SRC-1:0]          src_used_i,
  input  logic [ADDR_W-1:0]           dst_addr_i,
  input  logic                        dst_wr_i,
  input  logic                        is_load_i,
  input  logic                        branch_i,
  input  logic                        flush_i,
  output logic                        stall_o,
  output logic                        pc_write_o,
  output logic                        ifid_write_o,
  output logic                        idex_bubble_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [31:0]                 stall_total_o
);

  localparam int DEPTH = LOAD_LAT + 1;

  // Entry k holds the producer k+1 stages past ID (entry 0 is in EX).
  logic              validReg [DEPTH];
  logic [ADDR_W-1:0] addrReg  [DEPTH];
  logic              ldReg    [DEPTH];

  logic [DEPTH-1:0]   entryUnmet;
  logic [NUM_SRC-1:0] srcHazard;
  logic               hazard;
  logic               issueOk;

  logic [CNT_W-1:0] stallCntReg;
  logic [CNT_W-1:0] stallCntNext;
  logic [31:0]      stallTotalReg;
  logic [31:0]      stallTotalNext;

  // Per entry: would a consumer reading its result right now be too early?
  // A load needs LOAD_LAT stages of age, an ALU result none; a branch compare
  // in ID needs one stage more than an EX consumer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic LD_EARLY = (gi < LOAD_LAT) ? 1'b1 : 1'b0;
      localparam logic LD_EDGE  = (gi == LOAD_LAT) ? 1'b1 : 1'b0;
      localparam logic IS_HEAD  = (gi == 0) ? 1'b1 : 1'b0;
      assign entryUnmet[gi] = validReg[gi] &
                              (ldReg[gi] ? (LD_EARLY | (branch_i & LD_EDGE))
                                         : (branch_i & IS_HEAD));
    end
  endgenerate

  // Per source: the youngest matching entry decides whether the value is ready.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ADDR_W-1:0] srcAddr;
      logic              found;
      logic              unmet;
      assign srcAddr = src_addr_i[gi*ADDR_W +: ADDR_W];

      // Scan from youngest to oldest; first hit wins.
      always_comb begin
        found = 1'b0;
        unmet = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && validReg[k] && (addrReg[k] == srcAddr)) begin
            found = 1'b1;
            unmet = entryUnmet[k];
          end
        end
      end

      assign srcHazard[gi] = issue_valid_i & src_used_i[gi] &
                             (srcAddr != '0) & unmet;
    end
  endgenerate

  assign hazard        = |srcHazard;
  // A killed instruction never stalls, and reset suppresses the stall at once.
  assign stall_o       = hazard & ~flush_i & rst_n;
  assign pc_write_o    = ~stall_o;
  assign ifid_write_o  = ~stall_o;
  assign idex_bubble_o = stall_o | flush_i;
  assign issueOk       = issue_valid_i & ~stall_o & ~flush_i;

  // Head entry: the issuing instruction, or a bubble when nothing leaves ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validReg[0] <= 1'b0;
      addrReg[0]  <= '0;
      ldReg[0]    <= 1'b0;
    end else begin
      validReg[0] <= issueOk & dst_wr_i & (dst_addr_i != '0);
      addrReg[0]  <= dst_addr_i;
      ldReg[0]    <= is_load_i;
    end
  end

  // Older entries age by one stage every cycle, stalled or not.
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          validReg[gi] <= 1'b0;
          addrReg[gi]  <= '0;
          ldReg[gi]    <= 1'b0;
        end else begin
          validReg[gi] <= validReg[gi-1];
          addrReg[gi]  <= addrReg[gi-1];
          ldReg[gi]    <= ldReg[gi-1];
        end
      end
    end
  endgenerate

  // Saturating stall counters: run length clears on any non-stall cycle.
  always_comb begin
    stallCntNext   = '0;
    stallTotalNext = stallTotalReg;
    if (stall_o) begin
      stallCntNext = (stallCntReg == {CNT_W{1'b1}}) ? stallCntReg : stallCntReg + 1'b1;
      if (stallTotalReg != 32'hFFFF_FFFF) begin
        stallTotalNext = stallTotalReg + 32'd1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCntReg   <= '0;
      stallTotalReg <= '0;
    end else begin
      stallCntReg   <= stallCntNext;
      stallTotalReg <= stallTotalNext;
    end
  end

  assign stall_cnt_o   = stallCntReg;
  assign stall_total_o = stallTotalReg;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: one instance with LOAD_LAT=1, one
// with LOAD_LAT=3/CNT_W=2, both driven by the same instruction stream.
module tb_id_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issueValid;
  logic [9:0]  srcAddr;
  logic [1:0]  srcUsed;
  logic [4:0]  dstAddr;
  logic        dstWr;
  logic        isLoad;
  logic        branch;
  logic        flush;

  logic        stallA, pcWriteA, ifidWriteA, bubbleA;
  logic [3:0]  cntA;
  logic [31:0] totalA;
  logic        stallB, pcWriteB, ifidWriteB, bubbleB;
  logic [1:0]  cntB;
  logic [31:0] totalB;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  id_hazard_scoreboard dutA (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issueValid), .src_addr_i(srcAddr),
    .src_used_i(srcUsed), .dst_addr_i(dstAddr), .dst_wr_i(dstWr), .is_load_i(isLoad),
    .branch_i(branch), .flush_i(flush), .stall_o(stallA), .pc_write_o(pcWriteA),
    .ifid_write_o(ifidWriteA), .idex_bubble_o(bubbleA), .stall_cnt_o(cntA),
    .stall_total_o(totalA)
  );

  id_hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issueValid), .src_addr_i(srcAddr),
    .src_used_i(srcUsed), .dst_addr_i(dstAddr), .dst_wr_i(dstWr), .is_load_i(isLoad),
    .branch_i(branch), .flush_i(flush), .stall_o(stallB), .pc_write_o(pcWriteB),
    .ifid_write_o(ifidWriteB), .idex_bubble_o(bubbleB), .stall_cnt_o(cntB),
    .stall_total_o(totalB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction for one cycle; outputs settle 1ns later.
  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] dst, input logic wr,
                       input logic ld, input logic br, input logic fl);
    @(negedge clk);
    issueValid = v; srcAddr = {s1, s0}; srcUsed = used; dstAddr = dst;
    dstWr = wr; isLoad = ld; branch = br; flush = fl;
    #1;
    cycle++;
    $display("cyc %0d rst_n=%0b v=%0b src=%0d,%0d used=%b dst=%0d wr=%0b ld=%0b br=%0b fl=%0b | A stall=%0b cnt=%0d tot=%0d | B stall=%0b cnt=%0d tot=%0d",
             cycle, rst_n, v, s0, s1, used, dst, wr, ld, br, fl,
             stallA, cntA, totalA, stallB, cntB, totalB);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    issueValid = 1'b0; srcAddr = '0; srcUsed = '0; dstAddr = '0;
    dstWr = 1'b0; isLoad = 1'b0; branch = 1'b0; flush = 1'b0;

    // Reset state
    idle(2);
    checkEq("rst_stall", {31'd0, stallA}, 32'd0);
    checkEq("rst_pcw", {31'd0, pcWriteA}, 32'd1);
    checkEq("rst_ifidw", {31'd0, ifidWriteA}, 32'd1);
    checkEq("rst_cnt", {28'd0, cntA}, 32'd0);
    checkEq("rst_total", totalA, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: lw $2 ; add $3,$2,$4 -> one stall cycle
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    checkEq("t1_lw_stall", {31'd0, stallA}, 32'd0);
    drive(1, 2, 4, 2'b11, 3, 1, 0, 0, 0);
    checkEq("t1_use_stall", {31'd0, stallA}, 32'd1);
    checkEq("t1_use_pcw", {31'd0, pcWriteA}, 32'd0);
    checkEq("t1_use_ifidw", {31'd0, ifidWriteA}, 32'd0);
    checkEq("t1_use_bubble", {31'd0, bubbleA}, 32'd1);
    drive(1, 2, 4, 2'b11, 3, 1, 0, 0, 0);
    checkEq("t1_release", {31'd0, stallA}, 32'd0);
    checkEq("t1_cnt", {28'd0, cntA}, 32'd1);
    checkEq("t1_pcw_back", {31'd0, pcWriteA}, 32'd1);
    idle(1);
    checkEq("t1_cnt_clear", {28'd0, cntA}, 32'd0);
    idle(2);

    // 2: add $2 ; beq $2,$5 -> 1 stall.  lw $2 ; beq $2,$5 -> 2 stalls
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0);
    drive(1, 2, 5, 2'b11, 0, 0, 0, 1, 0);
    checkEq("t2_alu_br_stall", {31'd0, stallA}, 32'd1);
    drive(1, 2, 5, 2'b11, 0, 0, 0, 1, 0);
    checkEq("t2_alu_br_rel", {31'd0, stallA}, 32'd0);
    idle(3);
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    drive(1, 2, 5, 2'b11, 0, 0, 0, 1, 0);
    checkEq("t2_ld_br_s1", {31'd0, stallA}, 32'd1);
    drive(1, 2, 5, 2'b11, 0, 0, 0, 1, 0);
    checkEq("t2_ld_br_s2", {31'd0, stallA}, 32'd1);
    checkEq("t2_ld_br_cnt1", {28'd0, cntA}, 32'd1);
    drive(1, 2, 5, 2'b11, 0, 0, 0, 1, 0);
    checkEq("t2_ld_br_rel", {31'd0, stallA}, 32'd0);
    checkEq("t2_ld_br_cnt2", {28'd0, cntA}, 32'd2);
    checkEq("t2_total", totalA, 32'd4);
    idle(3);

    // 3: register 0 and unused sources never hazard
    drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 2'b11, 3, 1, 0, 0, 0);
    checkEq("t3_r0", {31'd0, stallA}, 32'd0);
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    drive(1, 2, 2, 2'b00, 0, 0, 0, 0, 0);
    checkEq("t3_unused", {31'd0, stallA}, 32'd0);
    idle(3);

    // 4: flush dominates a hazard and inserts nothing
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    drive(1, 2, 0, 2'b01, 6, 1, 1, 0, 1);
    checkEq("t4_flush_stall", {31'd0, stallA}, 32'd0);
    checkEq("t4_flush_bubble", {31'd0, bubbleA}, 32'd1);
    checkEq("t4_flush_pcw", {31'd0, pcWriteA}, 32'd1);
    drive(1, 6, 2, 2'b11, 0, 0, 0, 0, 0);
    checkEq("t4_no_insert", {31'd0, stallA}, 32'd0);
    idle(3);

    // 6: reset asserted during a stall
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    drive(1, 2, 4, 2'b11, 3, 1, 0, 0, 0);
    checkEq("t6_pre_stall", {31'd0, stallA}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkEq("t6_rst_stall", {31'd0, stallA}, 32'd0);
    checkEq("t6_rst_pcw", {31'd0, pcWriteA}, 32'd1);
    checkEq("t6_rst_bubble", {31'd0, bubbleA}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, 2, 4, 2'b11, 3, 1, 0, 0, 0);
    checkEq("t6_after_stall", {31'd0, stallA}, 32'd0);
    checkEq("t6_after_cnt", {28'd0, cntA}, 32'd0);
    checkEq("t6_after_total", totalA, 32'd0);
    idle(4);

    // 5: LOAD_LAT=3, CNT_W=2: lw $7 ; beq $7 -> 4 stalls, cnt 1,2,3,3
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
    checkEq("t5_lw_stall", {31'd0, stallB}, 32'd0);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    checkEq("t5_s1", {31'd0, stallB}, 32'd1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    checkEq("t5_s2", {31'd0, stallB}, 32'd1);
    checkEq("t5_cnt1", {30'd0, cntB}, 32'd1);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    checkEq("t5_s3", {31'd0, stallB}, 32'd1);
    checkEq("t5_cnt2", {30'd0, cntB}, 32'd2);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    checkEq("t5_s4", {31'd0, stallB}, 32'd1);
    checkEq("t5_cnt3", {30'd0, cntB}, 32'd3);
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    checkEq("t5_rel", {31'd0, stallB}, 32'd0);
    checkEq("t5_cnt_sat", {30'd0, cntB}, 32'd3);
    checkEq("t5_total", totalB, 32'd4);
    idle(1);
    checkEq("t5_cnt_clear", {30'd0, cntB}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
